// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared state encoding and width helpers for the factorial engine
//
// Contents:
//   state_t  : controller states IDLE / MUL / DONE
//   k_width  : width of the step counter k, one bit wider than the operand
//              so that k can hold n+1 for the largest n without wrapping

package factorial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int k_width(input int n_w);
        return n_w + 1;
    endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - N_W-cycle LSB-first shift-add multiplier
//
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   go      : hold high while steps are wanted; low clears the step in flight
//   a       : F_W-bit multiplicand, held stable by the parent for a whole step
//   b       : N_W-bit multiplier, held stable by the parent for a whole step
//   p       : F_W+N_W-bit product, valid when ready is high
//   ready   : high in the last cycle of a step; p already contains the final term
//
// A step is N_W cycles. The final partial product is folded into p
// combinationally, so the parent can capture the full result on the same edge
// that completes the last iteration, and the next step begins on the very
// following cycle with a cleared accumulator.

module seq_shift_add_mul #(
    parameter int N_W = 4,
    parameter int F_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic [F_W-1:0]     a,
    input  logic [N_W-1:0]     b,
    output logic [F_W+N_W-1:0] p,
    output logic               ready
);

    localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int P_W   = F_W + N_W;

    logic [CNT_W-1:0] r_i;
    logic [P_W-1:0]   r_p;

    logic [P_W-1:0]   w_a_ext;
    logic [P_W-1:0]   w_addend;
    logic [P_W-1:0]   w_p_sum;
    logic             w_last_iter;

    always_comb begin
        w_a_ext     = {{N_W{1'b0}}, a};
        w_addend    = b[r_i] ? (w_a_ext << r_i) : '0;
        w_p_sum     = r_p + w_addend;
        w_last_iter = (r_i == CNT_W'(N_W - 1));
    end

    assign p     = w_p_sum;
    assign ready = go && w_last_iter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= '0;
            r_p <= '0;
        end else if (!go || w_last_iter) begin
            // idle, or step finished: the next step starts from a clean product
            r_i <= '0;
            r_p <= '0;
        end else begin
            r_i <= r_i + CNT_W'(1);
            r_p <= w_p_sum;
        end
    end

endmodule

// File: rtl/factorial_param.sv
// rtl/factorial_param.sv - parametrised iterative factorial engine with start/busy/done handshake
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset; aborts any computation without done
//   start    : request, accepted on an edge while busy is low
//   n_in     : N_W-bit operand, sampled only when start is accepted
//   done     : one-cycle pulse, fact/overflow valid
//   busy     : high while multiplying; start is ignored
//   fact     : last result, held until the next done
//   overflow : last result exceeded F_W bits, updated with done
//
// acc is multiplied by k = 2..n, one N_W-cycle multiplier step per k, so the
// latency is exactly (n-1)*N_W cycles for n >= 2 and no early exit is taken.

module factorial_param
    import factorial_pkg::*;
#(
    parameter int N_W      = 4,
    parameter int F_W      = 16,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N_W-1:0] n_in,
    output logic           done,
    output logic           busy,
    output logic [F_W-1:0] fact,
    output logic           overflow
);

    localparam int K_W = k_width(N_W);
    localparam int P_W = F_W + N_W;

    state_t         r_state;
    state_t         w_state_next;

    logic [N_W-1:0] r_n;
    logic [F_W-1:0] r_acc;
    logic [K_W-1:0] r_k;
    logic           r_ovf;
    logic [F_W-1:0] r_fact;
    logic           r_overflow;

    logic           w_accept;
    logic           w_n_small;
    logic           w_step_done;
    logic           w_last_step;
    logic [P_W-1:0] w_mul_p;
    logic [F_W-1:0] w_acc_next;
    logic           w_ovf_next;
    logic           w_mul_go;

    assign w_accept    = start && (r_state != MUL);
    assign w_n_small   = (n_in <= N_W'(1));
    assign w_mul_go    = (r_state == MUL);
    assign w_last_step = w_step_done && (r_k == K_W'(r_n));
    assign w_acc_next  = w_mul_p[F_W-1:0];
    assign w_ovf_next  = r_ovf | (|w_mul_p[P_W-1:F_W]);

    seq_shift_add_mul #(
        .N_W (N_W),
        .F_W (F_W)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (w_mul_go),
        .a       (r_acc),
        .b       (r_k[N_W-1:0]),
        .p       (w_mul_p),
        .ready   (w_step_done)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic; DONE behaves like IDLE for acceptance, giving back-to-back runs
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_next = w_n_small ? DONE : MUL;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MUL: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        busy = (r_state == MUL);
        done = (r_state == DONE);
    end

    assign fact     = r_fact;
    assign overflow = r_overflow;

    // datapath: operand latch, running product, step counter and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n        <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_ovf      <= 1'b0;
            r_fact     <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_n   <= n_in;
            r_acc <= F_W'(1);
            r_k   <= K_W'(2);
            r_ovf <= 1'b0;
            if (w_n_small) begin
                r_fact     <= F_W'(1);
                r_overflow <= 1'b0;
            end
        end else if (r_state == MUL && w_step_done) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_next;
            if (w_last_step) begin
                r_fact     <= ((SATURATE != 0) && w_ovf_next) ? '1 : w_acc_next;
                r_overflow <= w_ovf_next;
            end else begin
                r_k <= r_k + K_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_factorial_param.sv
// tb/tb_factorial_param.sv - directed self-checking bench for factorial_param

module tb_factorial_param;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  n_in;

    logic        done1, busy1, ovf1;
    logic [15:0] fact1;
    logic        done0, busy0, ovf0;
    logic [15:0] fact0;

    int total = 0;
    int bad   = 0;

    factorial_param #(.N_W(4), .F_W(16), .SATURATE(1)) dut_sat (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .n_in     (n_in),
        .done     (done1),
        .busy     (busy1),
        .fact     (fact1),
        .overflow (ovf1)
    );

    factorial_param #(.N_W(4), .F_W(16), .SATURATE(0)) dut_trunc (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .n_in     (n_in),
        .done     (done0),
        .busy     (busy0),
        .fact     (fact0),
        .overflow (ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one isolated run; latency measured from the accept edge, busy cycles counted alongside
    task automatic run(input int n, input logic [15:0] ef_sat, input logic [15:0] ef_trunc,
                       input logic eovf, input int el);
        int cyc;
        int bcyc;
        logic [3:0] nv;
        nv = n[3:0];
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = nv;
        @(posedge clk); #1;
        start = 1'b0;
        n_in  = 4'hF;
        cyc  = 0;
        bcyc = 0;
        while (!done1 && cyc < 300) begin
            if (busy1) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("lat_n%0d", n), cyc, el);
        check($sformatf("busy_n%0d", n), bcyc, el);
        check($sformatf("fact_sat_n%0d", n), fact1, ef_sat);
        check($sformatf("ovf_sat_n%0d", n), ovf1, eovf);
        check($sformatf("done_trunc_n%0d", n), done0, 1'b1);
        check($sformatf("fact_trunc_n%0d", n), fact0, ef_trunc);
        check($sformatf("ovf_trunc_n%0d", n), ovf0, eovf);
        @(posedge clk); #1;
        check($sformatf("done_pulse_n%0d", n), done1, 1'b0);
        check($sformatf("fact_hold_n%0d", n), fact1, ef_sat);
    endtask

    initial begin
        int t;
        int ndone;
        int first_t;
        int dtimes[3];

        reset_n = 1'b0;
        start   = 1'b0;
        n_in    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fact", fact1, 16'h0000);
        check("rst_done", done1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_ovf",  ovf1,  1'b0);
        reset_n = 1'b1;

        // basic run and trivial operands
        run(6, 16'h02D0, 16'h02D0, 1'b0, 20);
        run(0, 16'h0001, 16'h0001, 1'b0, 0);
        run(1, 16'h0001, 16'h0001, 1'b0, 0);
        run(2, 16'h0002, 16'h0002, 1'b0, 4);

        // largest non-overflowing operand, then first overflowing one
        run(8, 16'h9D80, 16'h9D80, 1'b0, 28);
        run(9, 16'hFFFF, 16'h8980, 1'b1, 32);
        // fresh start after overflow must clear the flag
        run(3, 16'h0006, 16'h0006, 1'b0, 8);

        // start and n_in during MUL are ignored
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 4'd6;
        @(posedge clk); #1;
        start   = 1'b0;
        t       = 0;
        ndone   = 0;
        first_t = -1;
        while (t < 40) begin
            if (t == 5) begin
                start = 1'b1;
                n_in  = 4'd4;
            end
            if (t == 6) start = 1'b0;
            if (done1) begin
                ndone++;
                if (first_t < 0) first_t = t;
            end
            @(posedge clk); #1;
            t++;
        end
        check("ign_done_cnt", ndone, 1);
        check("ign_lat", first_t, 20);
        check("ign_fact", fact1, 16'd720);

        // asynchronous reset mid-run: outputs drop before the next edge
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_busy", busy1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_fact", fact1, 16'h0000);
        check("arst_done", done1, 1'b0);
        check("arst_busy", busy1, 1'b0);
        check("arst_ovf",  ovf1,  1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        t     = 0;
        ndone = 0;
        while (t < 40) begin
            if (done1 || busy1) ndone++;
            @(posedge clk); #1;
            t++;
        end
        check("arst_no_done", ndone, 0);
        run(4, 16'd24, 16'd24, 1'b0, 12);

        // start held high: back-to-back runs, one done every L+1 cycles
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 4'd3;
        t     = 0;
        ndone = 0;
        while (t < 60 && ndone < 3) begin
            @(posedge clk); #1;
            t++;
            if (done1) begin
                dtimes[ndone] = t;
                check($sformatf("b2b_fact%0d", ndone), fact1, 16'd6);
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("b2b_cnt", ndone, 3);
        check("b2b_t0", dtimes[0], 9);
        check("b2b_t1", dtimes[1], 18);
        check("b2b_t2", dtimes[2], 27);
        ndone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done1 || busy1) ndone++;
        end
        check("b2b_idle", ndone, 0);
        check("b2b_hold", fact1, 16'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/factorial_param.md
Name: factorial_param

Overview:
- Parametrised iterative factorial engine. Successor to the fixed 4-bit-in / 16-bit-out factorial block.
- Computes n! for an N_W-bit operand into an F_W-bit result using a sequential shift-add multiplier.
- Adds a start/busy/done handshake, overflow detection with a selectable saturate or truncate mode, and fixed, predictable latency.
- Used as a reusable arithmetic sequencer in the EC340 datapath exercises.

Parameters:
N_W, 4, operand width; n ranges 0..2^N_W-1.
F_W, 16, result width.
SATURATE, 1, 1: fact forced to all ones on overflow; 0: fact is n! mod 2^F_W.

Ports:
clk  input  1  system clock, rising-edge active.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on clk edges while busy=0.
n_in  input  N_W  operand; sampled only when start is accepted.
done  output  1  one-cycle pulse; result valid.
busy  output  1  high while computing; start is ignored.
fact  output  F_W  last result; held until the next done.
overflow  output  1  last result exceeded F_W bits; updated with done.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, fact=0, done=0, busy=0, overflow=0, internal acc/k/counters cleared. Reset mid-computation aborts the computation with no done.
- States: IDLE, MUL, DONE. busy = (state==MUL). done = (state==DONE).
- Accept: an edge with start=1 and state in {IDLE, DONE}.
  - Latch n=n_in, acc=1, k=2, ovf=0.
  - If n<=1, next state is DONE. Otherwise next state is MUL.
- Start during MUL is ignored. n_in changes during MUL are ignored.
- MUL, one step per k, exactly N_W cycles per step:
  - Product register P is F_W+N_W bits, cleared at step begin.
  - Iteration i (0..N_W-1), LSB first: if k[i]=1, P += acc<<i.
  - After iteration N_W-1:
    - acc = P[F_W-1:0].
    - ovf |= (P[F_W+N_W-1:F_W] != 0).
    - If k==n, next state is DONE; otherwise k = k+1 and a new step begins.
  - k is N_W+1 bits wide, so n = 2^N_W-1 never wraps.
- Entry to DONE registers the result:
  - fact = (SATURATE && ovf) ? all ones : acc.
  - overflow = ovf.
  - For n<=1: fact=1, overflow=0.
- DONE lasts one cycle. Next state is IDLE, or the new computation if start is accepted on that edge.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+L.
  - L = 0 for n<=1.
  - L = (n-1)*N_W for n>=2.
- Start held high gives back-to-back runs, with one done every L+1 cycles.
- Computation time is fixed; there is no early termination when overflow is detected.
- All arithmetic is unsigned.

Decomposition:
- Package factorial_pkg: state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2) and the width-derivation helper for the k counter (N_W+1).
- Sub-module seq_shift_add_mul: N_W-cycle shift-add multiplier.
  - Inputs: a[F_W], b[N_W], go.
  - Outputs: p[F_W+N_W], ready.
  - The parent FSM owns k, n, ovf and the outputs.

Test Plan (N_W=4, F_W=16, SATURATE=1 unless stated):
1. Release reset, start=1 for 1 cycle with n_in=6 -> busy high 20 cycles; done pulse with fact=0x02D0 (720), overflow=0.
2. n_in=0, then separately n_in=1 -> done in the cycle after accept, fact=0x0001, overflow=0, busy never high.
3. n_in=8 -> L=28, fact=0x9D80 (40320), overflow=0. Then n_in=9 -> fact=0xFFFF, overflow=1. With SATURATE=0 and n_in=9 -> fact=0x8980, overflow=1.
4. n_in=6 started, then start=1 with n_in=4 at cycle 5 -> ignored; done at L=20 with fact=720, no extra done.
5. reset_n low at cycle 10 of an n=7 run -> fact/done/busy/overflow are 0 before the next clk edge. After release, n_in=4 -> done at L=12, fact=24.
6. start held high, n_in=3 -> done pulses every 9 cycles (L=8, +1), each with fact=6; drop start -> return to IDLE after the final done.
